// File: rtl/lenet_pkg.sv
// Shared LeNet-5 working-memory geometry, buffer address widths and pool sequencer states.
package lenet_pkg;

  localparam int unsigned POOL1_CH  = 6;
  localparam int unsigned POOL1_DIM = 28;
  localparam int unsigned POOL1_HO  = POOL1_DIM / 2;
  localparam int unsigned POOL1_N   = POOL1_CH * POOL1_HO * POOL1_HO;

  localparam int unsigned POOL2_CH  = 16;
  localparam int unsigned POOL2_DIM = 10;
  localparam int unsigned POOL2_HO  = POOL2_DIM / 2;
  localparam int unsigned POOL2_N   = POOL2_CH * POOL2_HO * POOL2_HO;

  localparam int unsigned A_AW = 13;
  localparam int unsigned B_AW = 11;
  localparam int unsigned C_AW = 9;
  localparam int unsigned CH_W = 5;
  localparam int unsigned RC_W = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD0,
    S_RD1,
    S_RD2,
    S_RD3,
    S_WR,
    S_DONE
  } pool_state_t;

endpackage

// File: rtl/pool_addr_gen.sv
// Channel/row/column counters with running source and destination bases;
// every address comes from additions, never from multiplication.
module pool_addr_gen
  import lenet_pkg::*;
#(
  parameter int unsigned P1_CH  = POOL1_CH,
  parameter int unsigned P1_DIM = POOL1_DIM,
  parameter int unsigned P2_CH  = POOL2_CH,
  parameter int unsigned P2_DIM = POOL2_DIM
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            init,
  input  logic            adv,
  input  logic            layer,
  output logic [A_AW-1:0] win0_addr_c,
  output logic [A_AW-1:0] win1_addr_c,
  output logic [A_AW-1:0] win2_addr_c,
  output logic [A_AW-1:0] win3_addr_c,
  output logic [B_AW-1:0] dst_addr_c,
  output logic            last_c
);

  localparam logic [A_AW-1:0] W1     = A_AW'(P1_DIM);
  localparam logic [A_AW-1:0] W2     = A_AW'(P2_DIM);
  localparam logic [CH_W-1:0] CH1_MX = CH_W'(P1_CH - 1);
  localparam logic [CH_W-1:0] CH2_MX = CH_W'(P2_CH - 1);
  localparam logic [RC_W-1:0] HO1_MX = RC_W'(P1_DIM / 2 - 1);
  localparam logic [RC_W-1:0] HO2_MX = RC_W'(P2_DIM / 2 - 1);

  logic [A_AW-1:0] w;
  logic [A_AW-1:0] pos_q;
  logic [A_AW-1:0] row_q;
  logic [A_AW-1:0] row_next;
  logic [B_AW-1:0] dst_q;
  logic [CH_W-1:0] ch_q;
  logic [CH_W-1:0] ch_mx;
  logic [RC_W-1:0] r_q;
  logic [RC_W-1:0] c_q;
  logic [RC_W-1:0] ho_mx;

  assign w     = layer ? W2 : W1;
  assign ch_mx = layer ? CH2_MX : CH1_MX;
  assign ho_mx = layer ? HO2_MX : HO1_MX;

  // Two input rows per output row; after the last row this lands on the next channel base.
  assign row_next = row_q + w + w;

  assign win0_addr_c = pos_q;
  assign win1_addr_c = pos_q + A_AW'(1);
  assign win2_addr_c = pos_q + w;
  assign win3_addr_c = pos_q + w + A_AW'(1);
  assign dst_addr_c  = dst_q;
  assign last_c      = (ch_q == ch_mx) && (r_q == ho_mx) && (c_q == ho_mx);

  always_ff @(posedge clk) begin
    if (rst || init) begin
      pos_q <= '0;
      row_q <= '0;
      dst_q <= '0;
      ch_q  <= '0;
      r_q   <= '0;
      c_q   <= '0;
    end else if (adv) begin
      dst_q <= dst_q + B_AW'(1);
      if (c_q == ho_mx) begin
        c_q   <= '0;
        row_q <= row_next;
        pos_q <= row_next;
        if (r_q == ho_mx) begin
          r_q  <= '0;
          ch_q <= ch_q + CH_W'(1);
        end else begin
          r_q <= r_q + RC_W'(1);
        end
      end else begin
        c_q   <= c_q + RC_W'(1);
        pos_q <= pos_q + A_AW'(2);
      end
    end
  end

endmodule

// File: rtl/pool_ctrl.sv
// 2x2/stride-2 signed max-pool sequencer: Buffer A -> Buffer B (Pool1) or Buffer C (Pool2).
module pool_ctrl
  import lenet_pkg::*;
#(
  parameter int unsigned DW     = 8,
  parameter int unsigned P1_CH  = POOL1_CH,
  parameter int unsigned P1_DIM = POOL1_DIM,
  parameter int unsigned P2_CH  = POOL2_CH,
  parameter int unsigned P2_DIM = POOL2_DIM
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            layer_sel,
  output logic            busy,
  output logic            done,
  output logic [12:0]     buf_a_addr,
  input  logic [DW-1:0]   buf_a_rd_data,
  output logic [10:0]     buf_b_addr,
  output logic [DW-1:0]   buf_b_wr_data,
  output logic            buf_b_wr_en,
  output logic [8:0]      buf_c_addr,
  output logic [DW-1:0]   buf_c_wr_data,
  output logic            buf_c_wr_en
);

  pool_state_t     state_q;
  logic            layer_q;
  logic            last_q;
  logic [DW-1:0]   max_q;
  logic [DW-1:0]   max_nxt_c;
  logic            init_c;
  logic            adv_c;
  logic [A_AW-1:0] win0_addr_c;
  logic [A_AW-1:0] win1_addr_c;
  logic [A_AW-1:0] win2_addr_c;
  logic [A_AW-1:0] win3_addr_c;
  logic [B_AW-1:0] dst_addr_c;
  logic            last_c;

  assign init_c    = (state_q == S_IDLE) && start;
  assign adv_c     = (state_q == S_RD3);
  // Strictly-greater replaces, so ties keep the current value.
  assign max_nxt_c = ($signed(buf_a_rd_data) > $signed(max_q)) ? buf_a_rd_data : max_q;

  pool_addr_gen #(
    .P1_CH (P1_CH),
    .P1_DIM(P1_DIM),
    .P2_CH (P2_CH),
    .P2_DIM(P2_DIM)
  ) u_addr_gen (
    .clk        (clk),
    .rst        (rst),
    .init       (init_c),
    .adv        (adv_c),
    .layer      (layer_q),
    .win0_addr_c(win0_addr_c),
    .win1_addr_c(win1_addr_c),
    .win2_addr_c(win2_addr_c),
    .win3_addr_c(win3_addr_c),
    .dst_addr_c (dst_addr_c),
    .last_c     (last_c)
  );

  // Outputs are registered one state ahead: the edge entering a state loads that state's values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      layer_q       <= 1'b0;
      last_q        <= 1'b0;
      max_q         <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      buf_a_addr    <= '0;
      buf_b_addr    <= '0;
      buf_b_wr_data <= '0;
      buf_b_wr_en   <= 1'b0;
      buf_c_addr    <= '0;
      buf_c_wr_data <= '0;
      buf_c_wr_en   <= 1'b0;
    end else begin
      done          <= 1'b0;
      buf_a_addr    <= '0;
      buf_b_addr    <= '0;
      buf_b_wr_data <= '0;
      buf_b_wr_en   <= 1'b0;
      buf_c_addr    <= '0;
      buf_c_wr_data <= '0;
      buf_c_wr_en   <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            layer_q <= layer_sel;
            busy    <= 1'b1;
            state_q <= S_RD0;
          end
        end
        S_RD0: begin
          max_q      <= buf_a_rd_data;
          buf_a_addr <= win1_addr_c;
          state_q    <= S_RD1;
        end
        S_RD1: begin
          max_q      <= max_nxt_c;
          buf_a_addr <= win2_addr_c;
          state_q    <= S_RD2;
        end
        S_RD2: begin
          max_q      <= max_nxt_c;
          buf_a_addr <= win3_addr_c;
          state_q    <= S_RD3;
        end
        S_RD3: begin
          max_q   <= max_nxt_c;
          last_q  <= last_c;
          state_q <= S_WR;
          if (layer_q) begin
            buf_c_addr    <= C_AW'(dst_addr_c);
            buf_c_wr_data <= max_nxt_c;
            buf_c_wr_en   <= 1'b1;
          end else begin
            buf_b_addr    <= dst_addr_c;
            buf_b_wr_data <= max_nxt_c;
            buf_b_wr_en   <= 1'b1;
          end
        end
        S_WR: begin
          if (last_q) begin
            done    <= 1'b1;
            state_q <= S_DONE;
          end else begin
            buf_a_addr <= win0_addr_c;
            state_q    <= S_RD0;
          end
        end
        S_DONE: begin
          busy    <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          busy    <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pool_ctrl.sv
// Randomized scoreboard bench for pool_ctrl with a loop-based max-pool reference model.
module tb_pool_ctrl;
  import lenet_pkg::*;

  typedef struct packed {
    logic        port;
    logic [10:0] addr;
    logic [7:0]  data;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        layer_sel;
  logic        busy;
  logic        done;
  logic [12:0] buf_a_addr;
  logic [7:0]  buf_a_rd_data;
  logic [10:0] buf_b_addr;
  logic [7:0]  buf_b_wr_data;
  logic        buf_b_wr_en;
  logic [8:0]  buf_c_addr;
  logic [7:0]  buf_c_wr_data;
  logic        buf_c_wr_en;

  logic [7:0] mem   [0:4703];
  logic [7:0] b_got [0:2047];
  logic [7:0] c_got [0:511];
  wr_t        exp_q [$];

  int vectors     = 0;
  int miscompares = 0;
  int b_cnt       = 0;
  int c_cnt       = 0;
  int done_cnt    = 0;

  always #5 clk = ~clk;

  assign buf_a_rd_data = (buf_a_addr < 13'd4704) ? mem[buf_a_addr] : 8'h00;

  pool_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .layer_sel    (layer_sel),
    .busy         (busy),
    .done         (done),
    .buf_a_addr   (buf_a_addr),
    .buf_a_rd_data(buf_a_rd_data),
    .buf_b_addr   (buf_b_addr),
    .buf_b_wr_data(buf_b_wr_data),
    .buf_b_wr_en  (buf_b_wr_en),
    .buf_c_addr   (buf_c_addr),
    .buf_c_wr_data(buf_c_wr_data),
    .buf_c_wr_en  (buf_c_wr_en)
  );

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Reference: for every output, the signed maximum of its 2x2 input window, in output order.
  task automatic push_expect(input bit layer);
    int dim, nch, ho, dst, base;
    logic [7:0] m;
    logic [7:0] v [4];
    dim = layer ? POOL2_DIM : POOL1_DIM;
    nch = layer ? POOL2_CH : POOL1_CH;
    ho  = dim / 2;
    dst = 0;
    for (int ch = 0; ch < nch; ch++)
      for (int r = 0; r < ho; r++)
        for (int c = 0; c < ho; c++) begin
          base = ch * dim * dim + 2 * r * dim + 2 * c;
          v[0] = mem[base];
          v[1] = mem[base + 1];
          v[2] = mem[base + dim];
          v[3] = mem[base + dim + 1];
          m = v[0];
          for (int k = 1; k < 4; k++)
            if ($signed(v[k]) > $signed(m)) m = v[k];
          exp_q.push_back(wr_t'{layer, 11'(dst), m});
          dst++;
        end
  endtask

  // Monitor: every strobe pops one expected write.
  always @(negedge clk) begin
    wr_t got;
    wr_t exp;
    if (!rst) begin
      if (done) done_cnt++;
      if (buf_b_wr_en && buf_c_wr_en) check("dual_strobe", 64'd1, 64'd0);
      if (buf_b_wr_en || buf_c_wr_en) begin
        got.port = buf_c_wr_en;
        got.addr = buf_c_wr_en ? 11'(buf_c_addr) : buf_b_addr;
        got.data = buf_c_wr_en ? buf_c_wr_data : buf_b_wr_data;
        if (buf_c_wr_en) begin
          c_cnt++;
          c_got[buf_c_addr] = buf_c_wr_data;
        end else begin
          b_cnt++;
          b_got[buf_b_addr] = buf_b_wr_data;
        end
        if (exp_q.size() == 0) begin
          check("unexpected_wr", 64'(got), 64'hdead_beef);
        end else begin
          exp = exp_q.pop_front();
          check("wr", 64'(got), 64'(exp));
        end
      end
    end
  end

  task automatic run_layer(input bit layer, input int n_out, input bit poke, input bit chained);
    int nb0, nc0, dn0, done_at, last_n;
    push_expect(layer);
    nb0 = b_cnt;
    nc0 = c_cnt;
    dn0 = done_cnt;
    done_at = 0;
    last_n = 5 * n_out + 2;
    if (!chained) @(negedge clk);
    start = 1'b1;
    layer_sel = layer;
    @(posedge clk);
    #1;
    start = 1'b0;
    layer_sel = 1'($urandom);
    for (int n = 1; n <= last_n; n++) begin
      @(negedge clk);
      if (n == 1) check("first_rd0", {50'd0, busy, buf_a_addr}, {50'd0, 1'b1, 13'd0});
      if (done && done_at == 0) done_at = n;
      if (poke && n == 37) begin
        start = 1'b1;
        layer_sel = !layer;
      end else if (poke && n == 38) begin
        start = 1'b0;
      end
      if (n == 5 * n_out + 1) begin
        check("busy_in_done", 64'(busy), 64'd1);
        if (poke) begin
          start = 1'b1;
          layer_sel = !layer;
        end
      end
      if (n == last_n) begin
        check("idle_after_done", {62'd0, busy, done}, 64'd0);
        start = 1'b0;
      end
    end
    check("done_cycle", 64'(done_at), 64'(5 * n_out + 1));
    check("done_count", 64'(done_cnt - dn0), 64'd1);
    check("queue_left", 64'(exp_q.size()), 64'd0);
    check("b_writes", 64'(b_cnt - nb0), layer ? 64'd0 : 64'(n_out));
    check("c_writes", 64'(c_cnt - nc0), layer ? 64'(n_out) : 64'd0);
  endtask

  initial begin
    int nb0, nc0, dn0;
    rst = 1'b1;
    start = 1'b0;
    layer_sel = 1'b0;
    for (int i = 0; i < 4704; i++) mem[i] = 8'(i);
    repeat (3) @(negedge clk);
    check("reset_outs", {11'd0, busy, done, buf_b_wr_en, buf_c_wr_en, buf_a_addr, buf_b_addr,
                         buf_b_wr_data, buf_c_addr, buf_c_wr_data}, 64'd0);
    rst = 1'b0;

    // Pool1 on a ramp pattern.
    run_layer(1'b0, 1176, 1'b0, 1'b0);
    check("b0_ramp", 64'(b_got[0]), 64'd29);

    // Pool2 on random data with two hand-placed signed windows, stray starts, then a back-to-back run.
    for (int i = 0; i < 4704; i++) mem[i] = 8'($urandom);
    mem[0]  = 8'h80;  mem[1]  = 8'h7F;  mem[10] = 8'hFF;  mem[11] = 8'h00;
    mem[2]  = 8'h80;  mem[3]  = 8'h80;  mem[12] = 8'h80;  mem[13] = 8'h80;
    run_layer(1'b1, 400, 1'b1, 1'b0);
    check("c0_signed", 64'(c_got[0]), 64'h7F);
    check("c1_all_min", 64'(c_got[1]), 64'h80);
    run_layer(1'b1, 400, 1'b0, 1'b1);

    // Reset in the middle of Pool1.
    for (int i = 0; i < 4704; i++) mem[i] = 8'($urandom);
    push_expect(1'b0);
    @(negedge clk);
    start = 1'b1;
    layer_sel = 1'b0;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (300) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrun_rst_outs", {11'd0, busy, done, buf_b_wr_en, buf_c_wr_en, buf_a_addr, buf_b_addr,
                              buf_b_wr_data, buf_c_addr, buf_c_wr_data}, 64'd0);
    rst = 1'b0;
    exp_q.delete();
    nb0 = b_cnt;
    nc0 = c_cnt;
    dn0 = done_cnt;
    repeat (100) @(negedge clk);
    check("post_rst_quiet", 64'((b_cnt - nb0) + (c_cnt - nc0) + (done_cnt - dn0)), 64'd0);
    check("post_rst_idle", 64'(busy), 64'd0);
    run_layer(1'b0, 1176, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
